// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer:
// note codes, FSM states and width helpers.
package song_pkg;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_DO   = 4'h1;
  localparam logic [3:0] NOTE_RE   = 4'h2;
  localparam logic [3:0] NOTE_MI   = 4'h3;
  localparam logic [3:0] NOTE_FA   = 4'h4;
  localparam logic [3:0] NOTE_SO   = 4'h5;
  localparam logic [3:0] NOTE_LA   = 4'h6;
  localparam logic [3:0] NOTE_TI   = 4'h7;
  localparam logic [3:0] NOTE_PAD  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SKIP,
    S_PLAY,
    S_GAP
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sel_w(input int num_songs);
    return clog2_min1(num_songs);
  endfunction

  function automatic int idx_w(input int max_len);
    return clog2_min1(max_len);
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song library ROM: one registered read per cycle,
// data valid the cycle after the address.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int MAX_LEN   = 64,
  parameter int NOTE_W    = 4
) (
  input  logic                         clk,
  input  logic [sel_w(NUM_SONGS)-1:0]  song_sel,
  input  logic [idx_w(MAX_LEN)-1:0]    idx,
  output logic [NOTE_W-1:0]            code
);

  function automatic logic [3:0] lookup(
    input int s,
    input int i
  );
    logic [3:0] c;
    c = NOTE_PAD;
    case (s)
      // little star
      0: case (i)
        0, 1:    c = NOTE_DO;
        2, 3:    c = NOTE_SO;
        4, 5:    c = NOTE_LA;
        6:       c = NOTE_SO;
        default: c = NOTE_PAD;
      endcase
      // happy birthday, 8 leading pads
      1: case (i)
        8, 9:    c = NOTE_SO;
        10:      c = NOTE_LA;
        11:      c = NOTE_SO;
        12:      c = NOTE_DO;
        13:      c = NOTE_TI;
        14:      c = NOTE_REST;
        15, 16:  c = NOTE_SO;
        17:      c = NOTE_LA;
        18:      c = NOTE_SO;
        19:      c = NOTE_RE;
        20:      c = NOTE_DO;
        default: c = NOTE_PAD;
      endcase
      // two tigers, repeated to fill every slot
      2: case (i % 16)
        0, 3, 4, 7: c = NOTE_DO;
        1, 5:       c = NOTE_RE;
        2, 6, 8:    c = NOTE_MI;
        12:         c = NOTE_MI;
        9, 13:      c = NOTE_FA;
        10, 14:     c = NOTE_SO;
        default:    c = NOTE_REST;
      endcase
      default: c = NOTE_PAD;
    endcase
    return c;
  endfunction

  // registered read
  always_ff @(posedge clk) begin
    code <= NOTE_W'(lookup(int'(song_sel), int'(idx)));
  end

endmodule

// File: rtl/song_sequencer.sv
// Plays one ROM song note-by-note at a fixed tempo,
// with pause, stop, loop and leading-pad skipping.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_SONGS  = 4,
  parameter int MAX_LEN    = 64,
  parameter int NOTE_W     = 4,
  parameter int TICK_DIV   = 100000,
  parameter int NOTE_TICKS = 25,
  parameter int GAP_TICKS  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic [sel_w(NUM_SONGS)-1:0]  song_sel,
  input  logic                         loop_en,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         note_valid,
  output logic [idx_w(MAX_LEN)-1:0]    note_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int SW   = sel_w(NUM_SONGS);
  localparam int IW   = idx_w(MAX_LEN);
  localparam int PW   = clog2_min1(TICK_DIV);
  localparam int TMAX =
    (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = clog2_min1(TMAX);

  localparam logic [IW-1:0] LAST = IW'(MAX_LEN - 1);
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] NOTE_END = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_END =
    TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [NOTE_W-1:0] PAD_CODE = NOTE_W'(NOTE_PAD);

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [PW-1:0]     pre_q;
  logic [TW-1:0]     tick_q;
  logic [NOTE_W-1:0] note_q;
  logic [SW-1:0]     sel_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              played_q;
  logic              loop_q;

  logic [NOTE_W-1:0] rom_code;
  logic [IW-1:0]     rom_idx;
  logic              freeze;
  logic              tick;
  logic              note_end;
  logic              gap_end;
  logic              last_slot;
  logic              next_pad;
  logic [IW-1:0]     adv_idx;
  state_e            adv_state;
  logic              adv_done;
  logic              adv_wrap;

  assign freeze    = pause && (state_q != S_IDLE);
  assign tick      = (pre_q == PRE_END);
  assign note_end  = tick && (tick_q == NOTE_END);
  assign gap_end   = tick && (tick_q == GAP_END);
  assign last_slot = (idx_q == LAST);
  assign next_pad  = (rom_code == PAD_CODE);

  // look one slot ahead while sounding so the end test is ready
  always_comb begin
    rom_idx = idx_q;
    if ((state_q == S_PLAY || state_q == S_GAP) && !last_slot)
      rom_idx = idx_q + IW'(1);
  end

  // where to go once a note (and its gap) has finished
  always_comb begin
    adv_idx   = idx_q + IW'(1);
    adv_state = S_FETCH;
    adv_done  = 1'b0;
    adv_wrap  = 1'b0;
    if (last_slot || next_pad) begin
      if (loop_q) begin
        adv_idx  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_idx   = idx_q;
        adv_state = S_IDLE;
        adv_done  = 1'b1;
      end
    end
  end

  song_rom #(
    .NUM_SONGS (NUM_SONGS),
    .MAX_LEN   (MAX_LEN),
    .NOTE_W    (NOTE_W)
  ) u_rom (
    .clk      (clk),
    .song_sel (sel_q),
    .idx      (rom_idx),
    .code     (rom_code)
  );

  // playback FSM with tempo counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pre_q    <= '0;
      tick_q   <= '0;
      note_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      played_q <= 1'b0;
      loop_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        note_q  <= '0;
        busy_q  <= 1'b0;
        pre_q   <= '0;
        tick_q  <= '0;
      end else if (!freeze) begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q  <= S_FETCH;
              idx_q    <= '0;
              sel_q    <= song_sel;
              loop_q   <= loop_en;
              busy_q   <= 1'b1;
              played_q <= 1'b0;
            end
          end
          S_FETCH: state_q <= S_SKIP;
          S_SKIP: begin
            if (rom_code == PAD_CODE) begin
              if (!played_q && !last_slot) begin
                idx_q   <= idx_q + IW'(1);
                state_q <= S_FETCH;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              note_q   <= rom_code;
              valid_q  <= (rom_code != '0);
              played_q <= 1'b1;
              pre_q    <= '0;
              tick_q   <= '0;
              state_q  <= S_PLAY;
            end
          end
          S_PLAY: begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) tick_q <= tick_q + TW'(1);
            if (note_end) begin
              pre_q  <= '0;
              tick_q <= '0;
              note_q <= '0;
              if (GAP_TICKS > 0) begin
                state_q <= S_GAP;
              end else begin
                state_q <= adv_state;
                idx_q   <= adv_idx;
                done_q  <= adv_done;
                busy_q  <= ~adv_done;
                if (adv_wrap) played_q <= 1'b0;
              end
            end
          end
          S_GAP: begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) tick_q <= tick_q + TW'(1);
            if (gap_end) begin
              pre_q   <= '0;
              tick_q  <= '0;
              state_q <= adv_state;
              idx_q   <= adv_idx;
              done_q  <= adv_done;
              busy_q  <= ~adv_done;
              if (adv_wrap) played_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign note_out   = freeze ? '0 : note_q;
  assign note_valid = valid_q;
  assign note_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
